mmu_bus_dma: RTL
================

Name: mmu_bus_dma

Overview:
- Clocked, parametrised successor to the combinational memory map.
- Decodes CPU accesses for:
  - internal banked WRAM (C000-DFFF, echo E000-FDFF)
  - HRAM (FF80-FFFE)
  - IF (FF0F) and IE (FFFF)
  - OAM DMA (FF46), WRAM bank select (FF70), boot-ROM disable (FF50)
- Every other address is forwarded to an external bus (cart, VRAM, OAM, GPU/timer/sound I/O).
- Contains the OAM DMA engine, which owns the external bus while a transfer runs.

Parameters:
- WRAM_BANKS, 2, total 4 KiB WRAM banks including bank 0; power of two, 2..8 (2 = DMG, 8 = CGB).
- HRAM_SIZE, 127, HRAM bytes starting at FF80; 1..127.
- DMA_LEN, 160, bytes per OAM DMA transfer; 1..256.
- DMA_STEP, 4, clock cycles per DMA byte; >= 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_rd  in  1  read strobe, one cycle per access.
- cpu_wr  in  1  write strobe, one cycle per access; never asserted together with cpu_rd.
- cpu_rdata  out  8  registered read data, valid the cycle after cpu_rd.
- ext_addr  out  16  external bus address.
- ext_wdata  out  8  external write data.
- ext_rd  out  1  external read strobe.
- ext_wr  out  1  external write strobe.
- ext_rdata  in  8  external read data, combinational, same cycle as ext_rd.
- oam_addr  out  8  OAM byte index written by DMA.
- oam_wdata  out  8  OAM write data.
- oam_wr  out  1  OAM write strobe, one cycle per byte.
- dma_active  out  1  high while a transfer is in progress.
- int_pending  in  5  IF flags from the interrupt controller.
- int_request  out  5  one-cycle pulse: IF bits to set.
- int_clear  out  5  one-cycle pulse: IF bits to clear.
- int_enable  out  5  IE register.
- boot_off  out  1  sticky boot-ROM-disabled flag.

Behaviour:
- Reset values: all outputs 0; bank register = 1; DMA source register = 0; DMA idle. WRAM and HRAM contents are not reset. Reset mid-DMA aborts the transfer immediately.
- Read latency: exactly 1 cycle for every region. cpu_rdata holds its value until the next read.
- Internal reads:
  - FF0F returns {3'b111, int_pending}.
  - FFFF returns {3'b111, int_enable}.
  - FF46 returns the last written source byte.
  - FF70 returns {5'b11111, bank}.
  - FF50 returns 8'hFF.
- WRAM mapping:
  - C000-CFFF → bank 0.
  - D000-DFFF → bank given by the bank register.
  - E000-FDFF → mirror of C000-DDFF, reads and writes.
- FF70 write: bank = wdata[2:0] & (WRAM_BANKS-1); a result of 0 is stored as 1.
- HRAM: FF80 .. FF80+HRAM_SIZE-1 is internal. The rest of FF80-FFFE reads 8'hFF and ignores writes.
- FF0F write: int_request = wdata[4:0] and int_clear = ~wdata[4:0] for exactly the next cycle, then both return to 0.
- FFFF write: int_enable = wdata[4:0].
- FF50 write of any nonzero value sets boot_off. Only reset clears it.
- External forwarding: any address not listed above drives ext_addr/ext_wdata combinationally from the CPU and pulses ext_rd/ext_wr in the same cycle as the CPU strobe.
- DMA start:
  - A write to FF46 in cycle T latches src = wdata.
  - Source bytes E0-FF are reduced by 20 (so they read WRAM).
  - dma_active rises at T+1; index i = 0, step counter = 0.
- DMA transfer:
  - Each cycle, the step counter increments.
  - When it reaches DMA_STEP-1, the engine reads address {src, i}. The read goes to internal WRAM if src is C0-DF, otherwise to ext_rd/ext_addr.
  - In that same cycle: oam_wr = 1, oam_addr = i, oam_wdata = the read data. Then i increments and the step counter wraps to 0.
  - After byte DMA_LEN-1 is written, dma_active falls in the following cycle.
  - Total active time is DMA_LEN*DMA_STEP cycles.
- CPU access during DMA:
  - Only HRAM, FFFF and FF46 are accessible.
  - All other reads return 8'hFF; all other writes are dropped (no ext_wr, no internal effect).
  - The CPU never drives the ext_* bus while dma_active is high.
- FF46 write while dma_active: restarts the transfer with the new source; i and the step counter reset to 0 and dma_active stays high.
- A DMA source read of FE-FF (after the E0-FF reduction, i.e. DE-DF) returns internal WRAM data.

Test Plan:
- Reset, then read FF70, FFFF and D000 after a write of 8'h5A to D000 → 8'hF9, 8'hE0, 8'h5A; a read of F000 returns 8'h5A (echo).
- WRAM_BANKS=8: write 8'h03 to FF70 then 8'h11 to D000; write 8'h00 to FF70 (bank becomes 1) then 8'h22 to D000; set bank 3 and read D000 → 8'h11; FF70 reads 8'hFB.
- Write 8'h05 to FF0F → next cycle int_request=5'h05, int_clear=5'h1A; both 0 the cycle after.
- DMA from source 8'h12, ext_rdata = low address byte:
  - dma_active high for 640 cycles.
  - 160 oam_wr pulses, 4 cycles apart; oam_addr 0..159 with matching oam_wdata.
  - ext_addr runs 1200..129F.
- During DMA: read C000 → 8'hFF, no ext_rd from the CPU; HRAM FF90 write/read 8'h77 → 8'h77.
- Restart FF46=8'hC1 mid-transfer at i=50: oam_addr restarts at 0; data comes from WRAM C100+; total dma_active time is measured from the restart; asserting rst_n low mid-DMA drops dma_active immediately.

Source files
------------

// File: rtl/mmu_bus_dma_if.sv
// Bus bundle between the CPU-side memory map and its surroundings.
// Handshake: there is no ready/valid back-pressure. cpu_rd/cpu_wr are
// single-cycle strobes (never both high), cpu_rdata is valid the cycle after
// cpu_rd and holds until the next read; ext_rd/ext_wr/oam_wr are single-cycle
// strobes qualified by their address/data in the same cycle, and ext_rdata is
// returned combinationally in the cycle of ext_rd.
interface mmu_bus_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_rdata;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_rd;
  logic        ext_wr;
  logic [7:0]  ext_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_wr;
  logic        dma_active;
  logic [4:0]  int_pending;
  logic [4:0]  int_request;
  logic [4:0]  int_clear;
  logic [4:0]  int_enable;
  logic        boot_off;
  logic        dma_state;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr, ext_rdata, int_pending,
    output cpu_rdata, ext_addr, ext_wdata, ext_rd, ext_wr,
           oam_addr, oam_wdata, oam_wr, dma_active,
           int_request, int_clear, int_enable, boot_off, dma_state
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_rd, cpu_wr, ext_rdata, int_pending,
    input  cpu_rdata, ext_addr, ext_wdata, ext_rd, ext_wr,
           oam_addr, oam_wdata, oam_wr, dma_active,
           int_request, int_clear, int_enable, boot_off, dma_state
  );
endinterface

// File: rtl/mmu_bus_dma.sv
// Clocked memory map: banked WRAM, HRAM, IF/IE, bank select, boot-ROM
// disable and the OAM DMA engine. Everything else goes to the external bus.
// dma_state mirrors the DMA FSM (0 = idle, 1 = running) for observation.
module mmu_bus_dma #(
  parameter int WRAM_BANKS = 2,
  parameter int HRAM_SIZE  = 127,
  parameter int DMA_LEN    = 160,
  parameter int DMA_STEP   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mmu_bus_dma_if.slave bus
);

  localparam int BW = (WRAM_BANKS > 1) ? $clog2(WRAM_BANKS) : 1;
  localparam int AW = BW + 12;
  localparam int SW = (DMA_STEP > 1) ? $clog2(DMA_STEP) : 1;
  localparam logic [2:0]    BANK_MASK = 3'(WRAM_BANKS - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(DMA_STEP - 1);
  localparam logic [7:0]    IDX_LAST  = 8'(DMA_LEN - 1);
  localparam logic [7:0]    HRAM_END  = 8'(HRAM_SIZE);

  typedef enum logic {DMA_IDLE = 1'b0, DMA_RUN = 1'b1} dma_state_t;

  dma_state_t      state;
  logic            dma_active_q;
  logic [7:0]      dma_src;
  logic [7:0]      dma_page;
  logic [7:0]      dma_idx;
  logic [SW-1:0]   dma_step;
  logic [2:0]      bank;
  logic [4:0]      int_enable_q;
  logic [4:0]      int_request_q;
  logic [4:0]      int_clear_q;
  logic            boot_off_q;
  logic [7:0]      rdata_q;

  logic [7:0] wram [WRAM_BANKS*4096];
  logic [7:0] hram [HRAM_SIZE];

  // WRAM index for a C000-DFFF address (echo already folds onto the same
  // low 13 bits, since E000-FDFF only differs from C000-DDFF in bit 13).
  function automatic logic [AW-1:0] wram_index(input logic [12:0] ea,
                                               input logic [2:0]  bk);
    logic [BW-1:0] b;
    b = ea[12] ? bk[BW-1:0] : '0;
    return {b, ea[11:0]};
  endfunction

  logic [15:0]   a;
  logic          hit_wram, hit_hram_zone, hit_hram;
  logic          hit_if, hit_ie, hit_dma, hit_bank, hit_boot, hit_ext;
  logic          dma_on, allowed, wr_ok, dma_start;
  logic          dma_fire, dma_internal;
  logic [15:0]   dma_addr;
  logic [6:0]    hram_idx;
  logic [AW-1:0] wram_rd_idx;
  logic [7:0]    wram_rd_data;
  logic [7:0]    rd_mux;

  // Address decode and CPU access gating while DMA owns the bus.
  always_comb begin
    a             = bus.cpu_addr;
    hit_wram      = (a >= 16'hC000) && (a <= 16'hFDFF);
    hit_hram_zone = (a[15:7] == 9'h1FF) && (a != 16'hFFFF);
    hram_idx      = a[6:0];
    hit_hram      = hit_hram_zone && ({1'b0, hram_idx} < HRAM_END);
    hit_if        = (a == 16'hFF0F);
    hit_ie        = (a == 16'hFFFF);
    hit_dma       = (a == 16'hFF46);
    hit_bank      = (a == 16'hFF70);
    hit_boot      = (a == 16'hFF50);
    hit_ext       = !(hit_wram || hit_hram_zone || hit_if || hit_ie ||
                      hit_dma || hit_bank || hit_boot);
    dma_on        = (state == DMA_RUN);
    allowed       = !dma_on || hit_hram_zone || hit_ie || hit_dma;
    wr_ok         = bus.cpu_wr && allowed;
    dma_start     = wr_ok && hit_dma;
    dma_addr      = {dma_page, dma_idx};
    dma_fire      = dma_on && (dma_step == STEP_LAST);
    dma_internal  = (dma_page[7:5] == 3'b110);
  end

  // Single WRAM read port: DMA has it while running, the CPU otherwise.
  always_comb begin
    wram_rd_idx  = dma_on ? wram_index(dma_addr[12:0], bank)
                          : wram_index(a[12:0], bank);
    wram_rd_data = wram[wram_rd_idx];
  end

  // CPU read data selection; blocked regions read as FF.
  always_comb begin
    rd_mux = 8'hFF;
    if (!allowed)           rd_mux = 8'hFF;
    else if (hit_wram)      rd_mux = wram_rd_data;
    else if (hit_hram)      rd_mux = hram[hram_idx];
    else if (hit_hram_zone) rd_mux = 8'hFF;
    else if (hit_if)        rd_mux = {3'b111, bus.int_pending};
    else if (hit_ie)        rd_mux = {3'b111, int_enable_q};
    else if (hit_dma)       rd_mux = dma_src;
    else if (hit_bank)      rd_mux = {5'b11111, bank};
    else if (hit_boot)      rd_mux = 8'hFF;
    else                    rd_mux = bus.ext_rdata;
  end

  // External bus and OAM write port: DMA drives while active, CPU otherwise.
  always_comb begin
    bus.ext_addr  = dma_on ? dma_addr : a;
    bus.ext_wdata = dma_on ? 8'h00 : bus.cpu_wdata;
    bus.ext_rd    = dma_on ? (dma_fire && !dma_internal) : (bus.cpu_rd && hit_ext);
    bus.ext_wr    = !dma_on && bus.cpu_wr && hit_ext;
    bus.oam_wr    = dma_fire;
    bus.oam_addr  = dma_fire ? dma_idx : 8'h00;
    bus.oam_wdata = dma_fire ? (dma_internal ? wram_rd_data : bus.ext_rdata) : 8'h00;
  end

  // Memory write ports; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok && hit_wram) wram[wram_index(a[12:0], bank)] <= bus.cpu_wdata;
    if (wr_ok && hit_hram) hram[hram_idx] <= bus.cpu_wdata;
  end

  // Control registers, read data register and IF request/clear pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank          <= 3'd1;
      int_enable_q  <= '0;
      int_request_q <= '0;
      int_clear_q   <= '0;
      boot_off_q    <= 1'b0;
      rdata_q       <= '0;
    end else begin
      int_request_q <= '0;
      int_clear_q   <= '0;
      if (bus.cpu_rd) rdata_q <= rd_mux;
      if (wr_ok) begin
        if (hit_if) begin
          int_request_q <= bus.cpu_wdata[4:0];
          int_clear_q   <= ~bus.cpu_wdata[4:0];
        end
        if (hit_ie) int_enable_q <= bus.cpu_wdata[4:0];
        if (hit_bank) begin
          if ((bus.cpu_wdata[2:0] & BANK_MASK) == 3'd0) bank <= 3'd1;
          else bank <= bus.cpu_wdata[2:0] & BANK_MASK;
        end
        if (hit_boot && (bus.cpu_wdata != 8'h00)) boot_off_q <= 1'b1;
      end
    end
  end

  // OAM DMA FSM: an FF46 write (re)starts it, one byte every DMA_STEP cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= DMA_IDLE;
      dma_active_q <= 1'b0;
      dma_src      <= '0;
      dma_page     <= '0;
      dma_idx      <= '0;
      dma_step     <= '0;
    end else if (dma_start) begin
      state        <= DMA_RUN;
      dma_active_q <= 1'b1;
      dma_src      <= bus.cpu_wdata;
      dma_page     <= (bus.cpu_wdata >= 8'hE0) ? (bus.cpu_wdata - 8'h20) : bus.cpu_wdata;
      dma_idx      <= '0;
      dma_step     <= '0;
    end else begin
      case (state)
        DMA_IDLE: begin
          dma_active_q <= 1'b0;
        end
        DMA_RUN: begin
          if (dma_fire) begin
            dma_step <= '0;
            if (dma_idx == IDX_LAST) begin
              state        <= DMA_IDLE;
              dma_active_q <= 1'b0;
              dma_idx      <= '0;
            end else begin
              dma_idx <= dma_idx + 8'd1;
            end
          end else begin
            dma_step <= dma_step + 1'b1;
          end
        end
        default: begin
          state        <= DMA_IDLE;
          dma_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_rdata   = rdata_q;
  assign bus.dma_active  = dma_active_q;
  assign bus.int_request = int_request_q;
  assign bus.int_clear   = int_clear_q;
  assign bus.int_enable  = int_enable_q;
  assign bus.boot_off    = boot_off_q;
  assign bus.dma_state   = (state == DMA_RUN);

endmodule
